// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (CPU MEM stage vs. host port).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

    // Arbiter FSM state: IDLE lets the CPU own the port, GUARD hands one cycle to the host.
    typedef enum logic {
        IDLE  = 1'b0,
        GUARD = 1'b1
    } arb_state_e;

    // Memory-port owner select.
    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } arb_gnt_e;

    // Host wait cycles before a forced grant (legal range 1..255).
    localparam int DEFAULT_MAX_WAIT = 8;

    // Width of the host wait counter.
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/starve_counter.sv
// Saturating host wait counter; flags when the host has waited the configured limit.
// Latency: at_limit is a registered view of the count (one edge after the last increment).
// Backpressure: none; clr has priority over inc, count sticks at the limit.
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
)
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until the limit and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (fixed priority) and a host port.
// Latency: CPU path 0 cycles (combinational); host read data 1 cycle after accept.
// Backpressure: host_ready stalls the host; with DMEM_ARB_STARVE_GUARD_EN the host is forced in after MAX_WAIT, stalling the CPU one cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
)
(
    input  logic              clk,
    input  logic              reset,
    // MEM-stage side
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // Host / loader side
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    // Memory side
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              cpu_acc;
    logic              host_acc;
    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_gnt_e          gnt;
    logic [DATA_W-1:0] host_rdata_q;
    logic [DATA_W-1:0] host_rdata_d;
    logic              host_rvalid_q;
    logic              host_rvalid_d;

    assign cpu_acc  = cpu_re | cpu_we;
    assign host_acc = host_valid & host_ready;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic wait_inc;
    logic wait_clr;
    logic wait_at_limit;

    // The host is counted as waiting only while it is refused; any accept or withdrawal restarts it.
    assign wait_inc = host_valid & ~host_ready;
    assign wait_clr = host_acc | ~host_valid;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .at_limit (wait_at_limit)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a starved host with the CPU still busy earns one GUARD cycle, which always ends after one edge.
    always_comb begin
        state_d = IDLE;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        if ((state_q == IDLE) && wait_at_limit && host_valid && cpu_acc) begin
            state_d = GUARD;
        end
`endif
    end

    // FSM outputs: port owner, host_ready and pipeline stall, decoded from state and request inputs only.
    always_comb begin
        gnt        = GNT_CPU;
        host_ready = 1'b0;
        cpu_stall  = 1'b0;
        case (state_q)
            GUARD: begin
                gnt        = GNT_HOST;
                host_ready = 1'b1;
                cpu_stall  = 1'b1;
            end
            default: begin
                if (!cpu_acc && host_valid) begin
                    gnt        = GNT_HOST;
                    host_ready = 1'b1;
                end
            end
        endcase
        // Nothing may be accepted while reset is held, even though the FSM already sits in IDLE.
        if (!reset) begin
            host_ready = 1'b0;
        end
    end

    // Memory port mux; an idle port keeps the CPU address/data so the EX/MEM outputs flow straight through.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_re    = cpu_re;
        mem_we    = cpu_we;
        if (gnt == GNT_HOST) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_re    = host_valid & ~host_we;
            mem_we    = host_valid & host_we;
        end
        // Suppress any strobe during reset so a reset landing mid-GUARD cannot leak a write.
        if (!reset) begin
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    // Host read return: capture memory data on a read accept and pulse rvalid for one cycle.
    always_comb begin
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = host_acc & ~host_we;
        if (host_acc && !host_we) begin
            host_rdata_d = mem_rdata;
        end
    end

    // Host read return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign cpu_rdata   = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the five-stage pipeline's MEM stage and an external host/loader port used for program loading, debug reads and DMA-style fills. Sits between the EX/MEM pipeline register outputs and the data memory. The CPU has fixed priority; the host is served in idle cycles or, when the guard is compiled in, by stalling the pipeline for one cycle after bounded waiting. The block produces a `cpu_stall` that the hazard logic ORs into the PC, IF/ID, ID/EX and EX/MEM hold enables.

## Interface
- `ADDR_W`, 32, memory byte-address width
- `DATA_W`, 32, memory word width
- `MAX_WAIT`, 8, host wait cycles before a forced grant (range 1..255)

Ports:
- `clk` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `cpu_re` in 1: MEM-stage MemRead
- `cpu_we` in 1: MEM-stage MemWrite
- `cpu_addr` in ADDR_W: EX/MEM ALU result
- `cpu_wdata` in DATA_W: EX/MEM RD2
- `cpu_rdata` out DATA_W: read data to MEM/WB; combinational pass-through of `mem_rdata`
- `cpu_stall` out 1: pipeline hold request
- `host_valid` in 1: host request pending
- `host_we` in 1: 1 = write, 0 = read
- `host_addr` in ADDR_W: host address
- `host_wdata` in DATA_W: host write data
- `host_ready` out 1: request accepted this cycle
- `host_rvalid` out 1: one-cycle pulse; `host_rdata` valid
- `host_rdata` out DATA_W: registered read data
- `mem_re`, `mem_we` out 1: memory strobes
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data; combinational read, synchronous write

## Operation
- CPU access: `cpu_re | cpu_we`. Host request: `host_valid`.
- States:
  - IDLE: CPU owns the memory port.
  - GUARD: the host owns the port and the pipeline is stalled.
- In IDLE:
  - If a CPU access is present, the memory port carries the CPU signals and `host_ready` = 0.
  - Otherwise, if `host_valid` = 1, the port carries the host signals and `host_ready` = 1.
- Host accept (`host_valid & host_ready`):
  - For a read, `host_rdata` captures `mem_rdata` at that edge.
  - For a read, `host_rvalid` = 1 in the following cycle only.
  - A write produces no `host_rvalid`.
- Host handshake rules:
  - Host signals must stay stable while `host_valid` = 1 and `host_ready` = 0.
  - Deasserting `host_valid` before accept is allowed and drops the request.
- `wait_cnt` (8 bits):
  - Increments each cycle with `host_valid & !host_ready`.
  - Clears on accept or when `host_valid` = 0.
  - Saturates at `MAX_WAIT`.
- IDLE → GUARD when `wait_cnt == MAX_WAIT` and `host_valid` = 1 and a CPU access is present. Guard build only; see Configuration.
- In GUARD:
  - The port carries the host signals and `host_ready` = 1.
  - `cpu_stall` = 1. CPU strobes are masked, so no CPU write reaches memory.
  - GUARD → IDLE unconditionally next edge. The held CPU access repeats and is served in IDLE.
- If `host_valid` drops before GUARD is entered, no GUARD occurs and `wait_cnt` clears.
- Two consecutive GUARD cycles are impossible, because `wait_cnt` clears on accept.
- When neither side requests, `mem_re` = `mem_we` = 0; `mem_addr` and `mem_wdata` follow the CPU inputs.

## Timing
- Reset values: state = IDLE, `wait_cnt` = 0, `host_rdata` = 0, `host_rvalid` = 0, `cpu_stall` = 0.
- While reset is active, `host_ready` = 0 and `mem_we` = 0.
- Reset asserted mid-GUARD returns to IDLE immediately and discards the host access.
- CPU path latency is 0 cycles, with no added register.
- Host read latency is 1 cycle from accept to `host_rvalid`.
- `cpu_stall`, `host_ready` and the memory mux select are decoded from state and current inputs, with no combinational path from `mem_rdata`.
- Worst-case host wait under continuous CPU traffic: `MAX_WAIT` + 1 cycles from `host_valid` rise to accept.
- Simultaneous host accept and CPU access in IDLE cannot occur, because the CPU wins.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - The GUARD state and `wait_cnt` exist as described.
- Not defined:
  - Strict CPU priority; the host is served only in CPU-idle cycles.
  - `cpu_stall` is tied to 0 and `wait_cnt` is removed.
  - Unbounded host wait is accepted.

## Structure
- Package `dmem_arb_pkg` holds:
  - The state enum, with IDLE = 0 and GUARD = 1.
  - The grant encoding, GNT_CPU / GNT_HOST.
  - The default `MAX_WAIT` constant.
- One sub-module, `starve_counter`: the saturating wait counter with clear and increment inputs and an at-limit output. It is instantiated only under the macro.
- The memory mux and FSM live in the top module.

## Test plan
- Host read of address 0x40 (memory holds 0xDEADBEEF) with no CPU traffic → `host_ready` same cycle, `host_rvalid` next cycle, `host_rdata` = 0xDEADBEEF.
- CPU `sw` of 0x12345678 to 0x80 in the same cycle as a host write of 0xAAAA5555 to 0x80 → CPU write lands; `host_ready` = 0; host write lands the next idle cycle; final memory = 0xAAAA5555.
- Guard on, `MAX_WAIT` = 4, CPU accessing every cycle, host read pending →
  - Accept on cycle 5 with `cpu_stall` = 1 for exactly that cycle.
  - The held CPU access completes on cycle 6.
  - No CPU write is lost or duplicated.
- Guard off, same stimulus for 100 cycles → `host_ready` never asserts and `cpu_stall` stays 0.
- `reset` low during GUARD → outputs return to their reset values asynchronously; no `mem_we` pulse; `host_rvalid` = 0 after release.
- `host_valid` withdrawn after 3 wait cycles, then reasserted → `wait_cnt` restarts from 0; GUARD only after a further `MAX_WAIT` cycles.
